// File: rtl/encoder_83_if.sv
// Request/code bundle for the registered 8-to-3 priority encoder.
// oErr is present only when ENCODER83_ONEHOT_CHECK_EN is defined.
interface encoder_83_if;
  logic       iEn;
  logic [7:0] iData;
  logic [2:0] oData;
  logic       oValid;
`ifdef ENCODER83_ONEHOT_CHECK_EN
  logic       oErr;

  modport master (
    output iEn,
    output iData,
    input  oData,
    input  oValid,
    input  oErr
  );

  modport slave (
    input  iEn,
    input  iData,
    output oData,
    output oValid,
    output oErr
  );
`else
  modport master (
    output iEn,
    output iData,
    input  oData,
    input  oValid
  );

  modport slave (
    input  iEn,
    input  iData,
    output oData,
    output oValid
  );
`endif
endinterface

// File: rtl/encoder_83.sv
// Registered 8-to-3 priority encoder: highest set request bit wins, one cycle latency.
// Optional one-hot checker (oErr) enabled by defining ENCODER83_ONEHOT_CHECK_EN.
module encoder_83 (
  input logic         iClk,
  input logic         iRst,
  encoder_83_if.slave bus
);

  logic [2:0] codeD, codeQ;
  logic       validD, validQ;

  // Later (higher) bits overwrite earlier ones, giving bit 7 top priority.
  always_comb begin
    codeD = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.iData[i]) begin
        codeD = 3'(i);
      end
    end
  end

  assign validD = |bus.iData;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      codeQ  <= 3'd0;
      validQ <= 1'b0;
    end else if (bus.iEn) begin
      codeQ  <= codeD;
      validQ <= validD;
    end
  end

  assign bus.oData  = codeQ;
  assign bus.oValid = validQ;

`ifdef ENCODER83_ONEHOT_CHECK_EN
  logic       errD, errQ;
  logic [3:0] onesCount;

  // Flags both the all-zero and the multi-bit cases.
  always_comb begin
    onesCount = 4'd0;
    for (int i = 0; i < 8; i++) begin
      onesCount = onesCount + {3'd0, bus.iData[i]};
    end
  end

  assign errD = (onesCount != 4'd1);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      errQ <= 1'b0;
    end else if (bus.iEn) begin
      errQ <= errD;
    end
  end

  assign bus.oErr = errQ;
`endif

endmodule

// File: tb/tb_encoder_83.sv
// Scoreboard bench for encoder_83: driver queues hand-computed codes, monitor checks after each edge.
// Build with and without ENCODER83_ONEHOT_CHECK_EN; oData/oValid expectations are identical.
module tb_encoder_83;

  logic iClk;
  logic iRst;

  encoder_83_if bus ();

  encoder_83 dut (
    .iClk(iClk),
    .iRst(iRst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] stim;
    logic [2:0] code;
    logic       valid;
    logic       err;
  } exp_t;

  exp_t expQ[$];
  int   compCount = 0;
  int   errCount  = 0;

  initial begin
    iClk = 1'b0;
    forever #10 iClk = ~iClk;
  end

  task automatic check(input string name, input logic [7:0] stim,
                       input logic [31:0] act, input logic [31:0] req);
    compCount++;
    if (act !== req) begin
      errCount++;
      $display("FAIL %s stim=%02h actual=%0d required=%0d at %0t", name, stim, act, req, $time);
    end
  endtask

  task automatic checkOutputs(input string name, input exp_t e);
    check({name, ".oData"}, e.stim, 32'(bus.oData), 32'(e.code));
    check({name, ".oValid"}, e.stim, 32'(bus.oValid), 32'(e.valid));
`ifdef ENCODER83_ONEHOT_CHECK_EN
    check({name, ".oErr"}, e.stim, 32'(bus.oErr), 32'(e.err));
`endif
  endtask

  // Drive now and queue what the next rising edge must produce.
  task automatic drive(input logic [7:0] d, input logic en,
                       input logic [2:0] code, input logic valid, input logic err);
    exp_t e;
    bus.iData = d;
    bus.iEn   = en;
    e.stim  = d;
    e.code  = code;
    e.valid = valid;
    e.err   = err;
    expQ.push_back(e);
  endtask

  task automatic apply(input logic [7:0] d, input logic en,
                       input logic [2:0] code, input logic valid, input logic err);
    @(negedge iClk);
    drive(d, en, code, valid, err);
  endtask

  // Monitor: one queued expectation is consumed per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge iClk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutputs("capture", e);
      end
    end
  end

  initial begin
    exp_t zero;
    logic [7:0] oneHot;
    zero = '0;
    iRst      = 1'b0;
    bus.iEn   = 1'b1;
    bus.iData = 8'hFF;

    // Reset asserted between edges clears outputs at once and dominates iEn.
    #2 iRst = 1'b1;
    #2 checkOutputs("resetImmediate", zero);
    @(posedge iClk);
    #1 checkOutputs("resetHeld", zero);
    @(negedge iClk);
    iRst = 1'b0;
    drive(8'h00, 1'b0, 3'd0, 1'b0, 1'b0);

    oneHot = 8'b0000_0001;
    for (int i = 0; i < 8; i++) begin
      apply(oneHot, 1'b1, 3'(i), 1'b1, 1'b0);
      oneHot = oneHot << 1;
    end

    apply(8'h00, 1'b1, 3'd0, 1'b0, 1'b1);
    apply(8'hFF, 1'b0, 3'd0, 1'b0, 1'b1);
    apply(8'b1000_0001, 1'b1, 3'd7, 1'b1, 1'b1);
    apply(8'b0001_0110, 1'b1, 3'd4, 1'b1, 1'b1);
    apply(8'b0000_0011, 1'b1, 3'd1, 1'b1, 1'b1);
    apply(8'b1000_0000, 1'b1, 3'd7, 1'b1, 1'b0);

    apply(8'b0010_0000, 1'b1, 3'd5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(8'b0000_0010, 1'b0, 3'd5, 1'b1, 1'b0);
    end

    apply(8'b0100_0000, 1'b1, 3'd6, 1'b1, 1'b0);
    @(posedge iClk);
    #5 iRst = 1'b1;
    #1 checkOutputs("midReset", zero);
    @(posedge iClk);
    #1 checkOutputs("midResetHeld", zero);
    @(negedge iClk);
    iRst = 1'b0;
    drive(8'b0000_1000, 1'b1, 3'd3, 1'b1, 1'b0);
    apply(8'b0000_0100, 1'b1, 3'd2, 1'b1, 1'b0);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(posedge iClk);
    end
    #2;
    compCount++;
    if (expQ.size() != 0) begin
      errCount++;
      $display("FAIL drain pending=%0d required=0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule

// File: doc/encoder_83.md
# encoder_83

Registered 8-to-3 priority encoder (`encoder83`). It converts an 8-bit request vector, normally one-hot, into the 3-bit index of the active line. Output is registered, so downstream logic sees a clean, glitch-free code one clock after the input. It sits between one-hot sources (state decoders, arbiters, key scanners) and binary-indexed consumers such as muxes and display drivers.

## Interface

Parameters:
- none. Widths are fixed at 8 inputs and 3 output bits.

Ports:
- `iClk` input 1: single clock. All state updates on the rising edge.
- `iRst` input 1: reset, asynchronous, active-high.
- `iEn` input 1: capture enable. 1 = register the new encoding; 0 = hold all outputs.
- `iData` input 8: request vector. Bit n set means line n is active.
- `oData` output 3: binary index of the highest-numbered set bit of `iData`.
- `oValid` output 1: 1 when at least one bit of the captured `iData` was set.
- `oErr` output 1: exists only with `ENCODER83_ONEHOT_CHECK_EN`. 1 when the captured `iData` was not exactly one-hot.

## Operation

- Combinational priority: bit 7 has the highest priority and bit 0 the lowest. idx = largest n with `iData[n]` = 1.
- Pure one-hot mapping: 8'b00000001→0, 8'b00000010→1, 8'b00000100→2, 8'b00001000→3, 8'b00010000→4, 8'b00100000→5, 8'b01000000→6, 8'b10000000→7.
- All-zero input: next `oData` = 3'd0 and next `oValid` = 0.
- Multiple bits set: the highest set bit wins. Example: 8'b10000001→7 and 8'b00010110→4. `oValid` = 1.
- Capture rule on the rising edge:
  - When `iEn` = 1: `oData`, `oValid` (and `oErr`) take the encoding of the current `iData`.
  - When `iEn` = 0: all outputs hold their previous values.
- No state machine. One register stage holds the outputs; no other internal state.
- X or Z bits on `iData` are not supported. The bench must drive only 0/1.

## Timing

- Reset values: `oData` = 3'd0, `oValid` = 0, `oErr` = 0.
  - Outputs take these values immediately on `iRst` assertion, without waiting for a clock edge.
  - Outputs stay at these values for as long as `iRst` = 1, regardless of `iEn` and `iData`.
- First capture happens on the first rising `iClk` edge at which `iRst` = 0 and `iEn` = 1.
- Latency: exactly 1 cycle from `iData` at edge k to outputs valid after edge k.
- Throughput: one new code per cycle. Back-to-back input changes are encoded independently, with no hazards.
- Reset asserted mid-stream clears the outputs immediately. Any capture in flight is discarded.
- Outputs change only on a rising clock edge or on reset assertion. They never glitch on `iData` changes between edges.

## Configuration

Macro: `ENCODER83_ONEHOT_CHECK_EN`.
- Defined:
  - The `oErr` port exists.
  - Its next value is 1 when the population count of `iData` ≠ 1, covering both the zero case and the multi-bit case; otherwise it is 0.
  - It is registered with the same `iEn`/reset rules as the other outputs.
- Undefined:
  - The `oErr` port and its popcount logic are absent.
  - `oData`/`oValid` behaviour is identical to the defined case.

## Test plan

- Walk one-hot with `iEn` = 1, applying 8'b00000001 shifted left through 8'b10000000, one value every 20 ns. After each edge, require `oData` = 0,1,…,7 in order, `oValid` = 1, and `oErr` = 0.
- Zero input: `iData` = 8'h00 → after the edge `oData` = 0, `oValid` = 0, `oErr` = 1 (with the macro).
- Priority: apply 8'b10000001 → `oData` = 7 and `oErr` = 1. Then apply 8'b00010110 → `oData` = 4, `oValid` = 1, and `oErr` = 1.
- Hold: capture 8'b00100000 (`oData` = 5), then drop `iEn` to 0 and apply 8'b00000010 for 3 cycles. `oData` must stay 5.
- Async reset: with `oData` = 6, assert `iRst` between clock edges. Outputs must go to 0/0/0 before the next edge. Release `iRst` with `iData` = 8'b00001000 and `iEn` = 1: `oData` = 3 after the first edge.
- Build variants: run the full suite with and without `ENCODER83_ONEHOT_CHECK_EN`. `oData`/`oValid` traces must match exactly between the two builds.
